// File: rtl/dmem_resp_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states, request payload
// and byte-lane helpers.
package dmem_resp_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        uns;
    } req_t;

    // Byte-enable mask for an access of the given size at the given dword offset.
    function automatic logic [7:0] byte_strobe(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return 8'(base << offset);
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational load-lane extractor: shifts the addressed lane down and sign/zero extends it.
module dmem_lane
    import dmem_resp_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [63:0] value_c
);

    logic [63:0] shifted;

    assign shifted = word_i >> {offset_i, 3'b000};

    always_comb begin
        value_c = shifted;
        case (size_i)
            SZ_B: value_c = unsigned_i ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            SZ_H: value_c = unsigned_i ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: value_c = unsigned_i ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: value_c = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding data-memory responder with fixed latency, byte-lane stores and
// misalignment / range error responses.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t          req_q, req_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [63:0]   mem [DEPTH];

    req_t          req_in;
    req_t          src;
    logic          accept;
    logic          bad;
    logic          mem_we;
    logic [AW-1:0] idx;
    logic [7:0]    strobe;
    logic [63:0]   wdata_sh;
    logic [63:0]   load_val;

    assign req_in = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i,
                      size: req_size_i, uns: req_unsigned_i};

    // With LATENCY=1 the commit happens on the accept edge, so use the live request then.
    assign src      = (state_q == ST_IDLE) ? req_in : req_q;
    assign accept   = req_valid_i & ready_q;
    assign bad      = misaligned(req_in.size, req_in.addr[2:0]) |
                      (req_in.addr[63:3] >= 61'(DEPTH));
    assign idx      = src.addr[3 +: AW];
    assign strobe   = byte_strobe(src.size, src.addr[2:0]);
    assign wdata_sh = src.wdata << {src.addr[2:0], 3'b000};

    dmem_lane u_lane (
        .word_i     (mem[idx]),
        .offset_i   (src.addr[2:0]),
        .size_i     (src.size),
        .unsigned_i (src.uns),
        .value_c    (load_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d = req_in;
                    if (bad) begin
                        state_d = ST_RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (LATENCY <= 1) begin
                        state_d = ST_RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                        rdata_d = src.we ? 64'd0 : load_val;
                        mem_we  = src.we;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = src.we ? 64'd0 : load_val;
                    mem_we  = src.we;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (strobe[b]) mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter LATENCY, default 2, meaning cycles from request acceptance to resp_valid_o; legal range 1..15.
REQ-002 Parameter DEPTH, default 1024, meaning number of 64-bit storage words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  1  request present.
REQ-006 req_ready_o  output  1  responder can accept a request.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_addr_i  input  64  byte address (the ALU result).
REQ-009 req_wdata_i  input  64  store data, right-aligned.
REQ-010 req_size_i  input  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-011 req_unsigned_i  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-012 resp_valid_o  output  1  response present.
REQ-013 resp_ready_i  input  1  requester accepts response.
REQ-014 resp_rdata_o  output  64  extended load data; 0 for stores and errors.
REQ-015 resp_err_o  output  1  misaligned or out-of-range access, qualified by resp_valid_o.

Function
REQ-016 FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-017 IDLE: req_ready_o=1; a handshake (req_valid_i & req_ready_o) SHALL capture we, addr, wdata, size, unsigned.
REQ-018 WAIT and RESP: req_ready_o=0; only one request outstanding.
REQ-019 Misaligned access (addr not a multiple of 1<<size) SHALL go IDLE->RESP with resp_err_o=1, resp_valid_o one cycle after accept, no write.
REQ-020 Out-of-range access (addr[63:3] >= DEPTH) SHALL take the same error path as REQ-019.
REQ-021 Legal access: IDLE->WAIT, down-counter loaded with LATENCY-1; LATENCY=1 SHALL go directly to RESP.
REQ-022 WAIT->RESP when the counter reaches 0; resp_valid_o SHALL rise exactly LATENCY cycles after the accept edge.
REQ-023 Store SHALL write only byte lanes selected by addr[2:0] and size, on the WAIT->RESP (or IDLE->RESP) edge; other lanes unchanged.
REQ-024 Load SHALL read the word at addr[63:3], extract the lane at addr[2:0], and sign- or zero-extend to 64 bits; size 3 SHALL ignore req_unsigned_i.
REQ-025 Load data SHALL be registered into resp_rdata_o on entry to RESP and held stable while in RESP.
REQ-026 RESP: resp_valid_o=1 and outputs held until resp_ready_i=1; then RESP->IDLE, with resp_valid_o=0 next cycle.
REQ-027 resp_ready_i already high on the first RESP cycle SHALL complete the response in that single cycle.
REQ-028 A load following a store to the same address SHALL return the stored data.
REQ-029 req_valid_i while not ready SHALL be ignored; the requester holds it.

Reset
REQ-030 While rst_n=0: state IDLE, counter 0, req_ready_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
REQ-031 After release, req_ready_o=1 from the first clock edge on.
REQ-032 Reset mid-transaction SHALL abort it with no response; a pending store not yet committed SHALL NOT write.
REQ-033 Storage contents SHALL NOT be reset.

Structure
REQ-034 A shared package SHALL hold the size encodings (SZ_B/H/W/D), the FSM state enum, and a helper returning a byte-strobe from size and offset.
REQ-035 Lane extraction and extension SHALL be a combinational sub-module, dmem_lane (inputs word, offset, size, unsigned; output 64-bit value).

Verification
REQ-036 Store dword 0x1122334455667788 @0x40, then load dword @0x40, LATENCY=2 -> resp_valid_o 2 cycles after each accept, rdata 0x1122334455667788, err 0.
REQ-037 Store byte 0x80 @0x43, then signed load byte @0x43 -> 0xFFFFFFFFFFFFFF80; unsigned load -> 0x80; load dword @0x40 -> 0x1122334480667788.
REQ-038 Load word @0x42 -> resp one cycle after accept, err=1, rdata 0; a subsequent load dword @0x40 shows memory unchanged.
REQ-039 Load @ (DEPTH*8) -> err=1; resp_ready_i held low 5 cycles -> resp_valid_o, rdata and err stable all 5 cycles, req_ready_o=0 throughout.
REQ-040 Assert rst_n=0 one cycle after accepting a store of 0xAA @0x10 -> no response; after release, load byte @0x10 returns its prior value.
